// File: rtl/sonar_uc.sv
// sonar_uc: sweep / measure / transmit control FSM for the sonar datapath
module sonar_uc #(
  parameter int TIMEOUT = 2500000,
  parameter int TW = 22
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_1s,
  input  logic       medida_pronta,
  input  logic       serial_pronto,
  output logic       zera,
  output logic       conta_giro,
  output logic       conta_espera,
  output logic       inicio_medir,
  output logic       inicio_serial,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    GIRO        = 4'h2,
    ESPERA      = 4'h3,
    MEDIR       = 4'h4,
    AGUARDA_MED = 4'h5,
    TRANSMITE   = 4'h6,
    AGUARDA_TX  = 4'h7,
    PROXIMO     = 4'h8,
    ERRO        = 4'hF
  } state_t;
  state_t state, next;
  logic [TW-1:0] cnt;
  logic tmo;
  assign tmo = cnt == TW'(TIMEOUT - 1);
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= INICIAL;
    else state <= next;
  // measurement timeout counter: cleared when a measurement starts, saturates at its limit
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else if (state == MEDIR) cnt <= '0;
    else if (state == AGUARDA_MED && !tmo) cnt <= cnt + TW'(1);
  // erro follows the next state so it is high on the first ERRO cycle and low in PREPARA
  always_ff @(posedge clock or negedge reset)
    if (!reset) erro <= 1'b0;
    else if (next == ERRO) erro <= 1'b1;
    else if (next == PREPARA) erro <= 1'b0;
  // next-state logic; measurement completion beats a simultaneous timeout
  always_comb begin
    next = state;
    case (state)
      INICIAL:     next = ligar ? PREPARA : INICIAL;
      PREPARA:     next = GIRO;
      GIRO:        next = ESPERA;
      ESPERA:      next = fim_1s ? MEDIR : ESPERA;
      MEDIR:       next = AGUARDA_MED;
      AGUARDA_MED: next = medida_pronta ? TRANSMITE : tmo ? ERRO : AGUARDA_MED;
      TRANSMITE:   next = AGUARDA_TX;
      AGUARDA_TX:  next = serial_pronto ? PROXIMO : AGUARDA_TX;
      PROXIMO:     next = ligar ? GIRO : INICIAL;
      ERRO:        next = ligar ? ERRO : INICIAL;
      default:     next = INICIAL;
    endcase
  end
  // Moore outputs decoded from the current state only
  always_comb begin
    zera          = state == PREPARA;
    conta_giro    = state == GIRO;
    conta_espera  = state == ESPERA;
    inicio_medir  = state == MEDIR;
    inicio_serial = state == TRANSMITE;
    pronto        = state == PROXIMO;
    db_estado     = state;
  end
endmodule

// File: tb/tb_sonar_uc.sv
// tb_sonar_uc: randomized scoreboard bench for sonar_uc against a transition-table reference model
module tb_sonar_uc;
  localparam int TO = 20;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ligar = 1'b0, fim_1s = 1'b0, medida_pronta = 1'b0, serial_pronto = 1'b0;
  logic zera, conta_giro, conta_espera, inicio_medir, inicio_serial, pronto, erro;
  logic [3:0] db_estado;
  logic [10:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_state = 0;
  int m_age = 0;
  logic m_erro = 1'b0;
  sonar_uc #(.TIMEOUT(TO), .TW(5)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .fim_1s(fim_1s),
    .medida_pronta(medida_pronta), .serial_pronto(serial_pronto),
    .zera(zera), .conta_giro(conta_giro), .conta_espera(conta_espera),
    .inicio_medir(inicio_medir), .inicio_serial(inicio_serial), .pronto(pronto),
    .erro(erro), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  function automatic logic [10:0] observed();
    return {db_estado, zera, conta_giro, conta_espera, inicio_medir, inicio_serial, pronto, erro};
  endfunction
  function automatic logic [10:0] expect_of(int s, logic e);
    return {4'(s), s == 1, s == 2, s == 3, s == 4, s == 6, s == 8, e};
  endfunction
  // monitor: every cycle the DUT presents a new state, compare it with the oldest prediction
  always begin
    logic [10:0] e, a;
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = observed();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle t=%0t: got estado=%h outs=%b, expected estado=%h outs=%b",
                 $time, a[10:7], a[6:0], e[10:7], e[6:0]);
      end
    end
  end
  task automatic chk(string nm, logic [10:0] got, logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  // reference: spec-level transition rules, age = cycles already spent in the current state
  task automatic step(input logic l, input int mode);
    logic f, m, s;
    int n;
    @(negedge clock);
    f = mode == 0 ? $urandom_range(7) == 0 : (m_state == 3 && m_age == 3);
    s = mode == 0 ? $urandom_range(7) == 0 : (m_state == 7 && m_age == 8);
    m = mode == 0 ? $urandom_range(29) == 0 :
        mode == 1 ? (m_state == 5 && m_age == 5) :
        mode == 3 ? (m_state == 5 && m_age == TO - 1) : 1'b0;
    ligar = l; fim_1s = f; medida_pronta = m; serial_pronto = s;
    case (m_state)
      0: n = l ? 1 : 0;
      1: n = 2;
      2: n = 3;
      3: n = f ? 4 : 3;
      4: n = 5;
      5: n = m ? 6 : (m_age + 1 >= TO) ? 15 : 5;
      6: n = 7;
      7: n = s ? 8 : 7;
      8: n = l ? 2 : 0;
      default: n = l ? 15 : 0;
    endcase
    m_age = (n == m_state) ? m_age + 1 : 0;
    m_state = n;
    if (n == 15) m_erro = 1'b1;
    if (n == 1) m_erro = 1'b0;
    exp_q.push_back(expect_of(n, m_erro));
  endtask
  task automatic run_until(input logic l, input int mode, input int target, input string nm);
    for (int i = 0; i < 300 && m_state != target; i++) step(l, mode);
    checks++;
    if (m_state != target) begin
      errors++;
      $display("FAIL %s: state %0d never reached, stuck at %0d", nm, target, m_state);
    end
  endtask
  initial begin
    logic lig;
    #1;
    chk("reset_outputs", observed(), 11'h0);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_held_over_edges", observed(), 11'h0);
    #1 reset = 1'b1;
    // nominal sweep, including spurious pulses seen in idle
    step(0, 0);
    step(0, 0);
    run_until(1, 1, 8, "nominal_reach_proximo");
    run_until(1, 1, 3, "nominal_second_position");
    // measurement timeout, then stop while in ERRO
    run_until(1, 2, 15, "timeout_reach_erro");
    repeat (3) step(1, 2);
    repeat (4) step(0, 2);
    // medida_pronta on the last counter value must win over the timeout
    run_until(1, 3, 6, "collision_reach_transmite");
    // stop request late in the cycle
    run_until(1, 1, 7, "stop_reach_aguarda_tx");
    repeat (30) step(0, 1);
    // randomized operation
    lig = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) lig = ~lig;
      step(lig, 0);
    end
    // asynchronous reset between edges while waiting for a measurement
    run_until(1, 1, 5, "async_reach_aguarda_med");
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_immediate", observed(), 11'h0);
    m_state = 0; m_age = 0; m_erro = 1'b0;
    @(posedge clock);
    #2;
    chk("async_reset_held", observed(), 11'h0);
    reset = 1'b1;
    step(1, 1);
    step(1, 1);
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sonar_uc.md
SONAR_UC -- requirements
Module: sonar_uc

Interface
REQ-001 Parameter TIMEOUT, default 2500000, sets the measurement timeout in clock cycles (50 ms at 50 MHz).
REQ-002 Parameter TW, default 22, sets the timeout counter width; TW SHALL satisfy 2^TW > TIMEOUT.
REQ-003 clock  input  1  system clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 ligar  input  1  level; 1 enables continuous sweep operation.
REQ-006 fim_1s  input  1  one-cycle pulse from the servo settle counter.
REQ-007 medida_pronta  input  1  one-cycle pulse from the sensor interface when a measurement is complete.
REQ-008 serial_pronto  input  1  one-cycle pulse from the serial transmitter when a frame is sent.
REQ-009 zera  output  1  synchronous clear for the position counter, settle counter and sensor interface.
REQ-010 conta_giro  output  1  one-cycle pulse that advances the servo position counter.
REQ-011 conta_espera  output  1  level; enables the settle counter.
REQ-012 inicio_medir  output  1  one-cycle pulse that starts the sensor measurement.
REQ-013 inicio_serial  output  1  one-cycle pulse that starts serial transmission.
REQ-014 pronto  output  1  one-cycle pulse when a full position cycle completes.
REQ-015 erro  output  1  level; set on measurement timeout.
REQ-016 db_estado  output  4  current state code.

Function
REQ-017 The FSM SHALL have these states and codes: INICIAL=0, PREPARA=1, GIRO=2, ESPERA=3, MEDIR=4, AGUARDA_MED=5, TRANSMITE=6, AGUARDA_TX=7, PROXIMO=8, ERRO=F.
REQ-018 The state register SHALL be updated only on rising clock edges or by reset; db_estado SHALL equal the current state code combinationally.
REQ-019 INICIAL SHALL go to PREPARA when ligar=1, and SHALL remain in INICIAL otherwise.
REQ-020 PREPARA: zera=1 for exactly one cycle, erro cleared, then GIRO.
REQ-021 GIRO: conta_giro=1 for one cycle, then ESPERA.
REQ-022 ESPERA: conta_espera=1 and stay until fim_1s=1, then MEDIR.
REQ-023 MEDIR: inicio_medir=1 for one cycle, timeout counter cleared to 0, then AGUARDA_MED.
REQ-024 AGUARDA_MED: timeout counter increments each cycle.
  - On medida_pronta=1, go to TRANSMITE.
  - If the counter reaches TIMEOUT-1 without medida_pronta, go to ERRO.
  - If medida_pronta=1 on the same cycle the counter reaches TIMEOUT-1, medida_pronta wins and the next state is TRANSMITE.
REQ-025 TRANSMITE: inicio_serial=1 for one cycle, then AGUARDA_TX.
REQ-026 AGUARDA_TX: stay until serial_pronto=1, then PROXIMO.
REQ-027 PROXIMO: pronto=1 for one cycle.
  - If ligar=1, go to GIRO; the next position is taken and there is no PREPARA.
  - If ligar=0, go to INICIAL.
REQ-028 ERRO: erro=1.
  - Stay in ERRO while ligar=1.
  - When ligar=0, go to INICIAL; erro stays 1 until the next PREPARA.
REQ-029 ligar=0 in states GIRO through AGUARDA_TX SHALL NOT abort the cycle; it takes effect only in PROXIMO.
REQ-030 Handshake input pulses received outside their waiting state (fim_1s outside ESPERA, medida_pronta outside AGUARDA_MED, serial_pronto outside AGUARDA_TX) SHALL be ignored.
REQ-031 All pulse outputs (zera, conta_giro, inicio_medir, inicio_serial, pronto) SHALL be Moore outputs decoded from state only, glitch-free, and never asserted simultaneously.
REQ-032 The timeout counter SHALL saturate and never wrap.
REQ-033 Latency from medida_pronta to the inicio_serial pulse SHALL be exactly 1 cycle.

Reset
REQ-034 With reset=0, the block SHALL immediately enter INICIAL, independent of clock.
REQ-035 With reset=0, all outputs SHALL be 0, db_estado=0 and the timeout counter=0.
REQ-036 Reset asserted mid-operation (any state, including ERRO) SHALL abandon the cycle with no further pulses.
REQ-037 Reset release SHALL be followed by INICIAL behaviour on the next rising edge.

Verification (TIMEOUT=20 overridden)
REQ-038 Nominal cycle: ligar=1, fim_1s 5 cycles after conta_giro, medida_pronta 7 cycles after inicio_medir, serial_pronto 10 cycles after inicio_serial -> states visited 0,1,2,3,4,5,6,7,8,2; exactly one pulse each of zera, conta_giro, inicio_medir, inicio_serial, pronto; erro=0.
REQ-039 Timeout: no medida_pronta after inicio_medir -> ERRO entered exactly 20 cycles after AGUARDA_MED entry, erro=1, inicio_serial never pulses; then ligar=0 -> INICIAL with erro still 1.
REQ-040 Timeout collision: medida_pronta on the cycle the counter hits 19 -> next state TRANSMITE, erro=0.
REQ-041 Stop request: ligar dropped while in AGUARDA_TX -> cycle completes, pronto pulses once, then INICIAL with no further conta_giro.
REQ-042 Spurious pulses: fim_1s, medida_pronta and serial_pronto driven in INICIAL and GIRO -> no state change caused by them.
REQ-043 Asynchronous reset: reset=0 asserted between clock edges while in AGUARDA_MED -> db_estado=0 and all outputs 0 before the next edge; after release with ligar=1 -> PREPARA.
